tqv_spi_bridge: RTL and testbench
=================================

# tqv_spi_bridge

Parametrised SPI-slave-to-peripheral-register bridge for the TinyQV peripheral test harness. It supersedes the single-shot SPI register port with multi-channel peripheral selection, burst transfers with address auto-increment, and a prefetching read pipeline. Read requests are bounded by a timeout. It sits between the synchronised SPI pins and up to CHANNELS TinyQV-style peripheral register buses.

## Interface
- ADDR_W, 6: peripheral register address width (1..8).
- CHANNELS, 2: number of peripheral buses (1..16); CH_W = max(1, clog2(CHANNELS)).
- TIMEOUT, 64: max clk cycles a read may wait for data_ready (2..255).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- spi_cs_n, spi_clk, spi_mosi  in  1 each  SPI mode 0, already 2-stage synchronised to clk.
- spi_miso  out  1  serial read data.
- chan_sel  out  CH_W  selected peripheral channel.
- address  out  ADDR_W  register address.
- data_in  out  32  write data to peripheral.
- data_write_n  out  2  11 = idle, else txn width (00 byte, 01 half, 10 word).
- data_read_n  out  2  same encoding for reads.
- data_out  in  32*CHANNELS  read data; channel c at [32c+31:32c].
- data_ready  in  CHANNELS  per-channel read-complete.
- rd_err  out  1  sticky: timeout or late read in current frame.
- busy  out  1  frame in progress (cs_n low).

## Operation
- Reset values: spi_miso 0, chan_sel 0, address 0, data_in 0, data_write_n 11, data_read_n 11, rd_err 0, busy 0; FSM in IDLE.
- spi_clk edges are detected from a registered copy. MOSI is sampled on the rising edge; MISO is updated on the falling edge. Bits are MSB first.
- Frame layout:
  - Byte 0, command: [7] write, [6:5] width (11 treated as 10), [4] burst, [3:0] channel. Only the low CH_W channel bits are used; channel ≥ CHANNELS maps to channel 0.
  - Byte 1: address; the low ADDR_W bits are used.
  - Then data. N = 1/2/4 bytes per word. Data bytes are most-significant byte first and right-aligned in data_in.
- FSM states: IDLE → CMD on cs_n fall; CMD → ADDR after 8 bits; ADDR → WDATA (write) or RWAIT (read) after 8 bits.
- Write:
  - After the 8N-th data bit, data_in is loaded (unused upper bits 0), chan_sel/address are held, and data_write_n = width for exactly 1 clk.
  - Burst: address += N, wrapping modulo 2^ADDR_W, and the FSM stays in WDATA. Non-burst: extra bytes are ignored.
- Read:
  - On entering RWAIT, data_read_n = width is asserted. It holds until data_ready[chan_sel] is sampled high; that data_out is captured masked to the width (upper bits 0) and data_read_n returns to 11 the next cycle.
  - If not ready after TIMEOUT cycles: deassert, capture 0, set rd_err.
  - The host sends one dummy byte after the address; read data shifts out starting with the following byte (RDATA).
  - If no word is captured by the first data bit, MISO sends 0 for that word and rd_err is set.
- Burst read pipeline:
  - The first captured word goes to the shift register.
  - Immediately after, the next read (address += N) is issued into a one-word prefetch buffer.
  - When the shift register empties, it reloads from the prefetch buffer and the next prefetch is issued.
  - At most one read is outstanding.
- Abort: cs_n rising in any state returns the FSM to IDLE and discards any partial byte/word (no write strobe).
  - An outstanding read is dropped: data_read_n goes to 11 the next clk, and a late data_ready is ignored.
  - rd_err holds until the next cs_n fall, which clears it. busy follows cs_n low with 1 clk latency.
- Strobe arbitration: data_write_n and data_read_n are never both active.

## Timing
- spi_clk half-period must be ≥ 4 clk cycles. External sync adds 2 cycles; edge detect adds 1.
- Write strobe occurs 1 clk after the detected rising edge of the last data bit.
- Read request is issued 1 clk after the last address bit.
- The read must complete within 8 spi_clk periods (the dummy byte) to be valid.
- MISO changes 1 clk after the detected falling edge. The first data bit is driven on the falling edge ending the dummy byte.

## Test plan
- Write word: cmd 0xC1, addr 0x05, data 0x12345678 → one-cycle data_write_n=10, chan_sel=1, address=5, data_in=0x12345678.
- Burst byte write: cmd 0x90, addr 0x3F, bytes 0xAA, 0xBB → strobes at addr 0x3F then 0x00 (wrap), data_in 0xAA then 0xBB, data_write_n=00.
- Read half: cmd 0x20, addr 0x02, channel 0 returns data_out 0xFFFFBEEF with data_ready after 3 clk → MISO shifts 0xBEEF, data_read_n=01 held 4 clk, rd_err 0.
- Burst word read: cmd 0x50, addr 0x04 → back-to-back words from 0x04, 0x08, 0x0C; never two reads outstanding.
- Timeout: data_ready held low → data_read_n released after TIMEOUT cycles, MISO sends 0x00000000, rd_err=1; the next cs_n fall clears it.
- Abort and reset: cs_n rises after 12 data bits of a write → no strobe, FSM IDLE. Asserting rst mid-read → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/tqv_spi_bridge.sv
// SPI-slave bridge onto TinyQV peripheral register buses:
// channel select, burst writes, prefetched burst reads with timeout.
module tqv_spi_bridge #(
  parameter int ADDR_W   = 6,
  parameter int CHANNELS = 2,
  parameter int TIMEOUT  = 64,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_cs_n,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  output logic [CH_W-1:0]         chan_sel,
  output logic [ADDR_W-1:0]       address,
  output logic [31:0]             data_in,
  output logic [1:0]              data_write_n,
  output logic [1:0]              data_read_n,
  input  logic [32*CHANNELS-1:0]  data_out,
  input  logic [CHANNELS-1:0]     data_ready,
  output logic                    rd_err,
  output logic                    busy
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RWAIT, RDATA
  } state_e;

  state_e            state_q;
  logic              sclk_q, busy_q, miso_q, rderr_q;
  logic [2:0]        bit_q;
  logic [6:0]        sh_q;
  logic              wr_q, burst_q;
  logic [1:0]        width_q, wn_q, rn_q, wcnt_q;
  logic [CH_W-1:0]   chan_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q, tx_q, pf_q;
  logic [23:0]       wacc_q;
  logic              wdone_q, adv_q, first_q;
  logic              iss_q, txv_q, pfv_q;
  logic [7:0]        tmr_q;
  logic [4:0]        obit_q;

  logic              rise, fall, byte_done;
  logic              rd_act, rdy, tmo, wlast, olast;
  logic [7:0]        byte_d;
  logic [31:0]       wword_d, rdat, mask, cap_d;
  logic [4:0]        lsh;
  logic [2:0]        nb;
  logic [5:0]        nbits;
  logic [ADDR_W-1:0] nb_a;

  assign rise      = spi_clk & ~sclk_q & ~spi_cs_n;
  assign fall      = ~spi_clk & sclk_q & ~spi_cs_n;
  assign byte_d    = {sh_q, spi_mosi};
  assign byte_done = rise && (bit_q == 3'd7);
  assign wword_d   = {wacc_q, byte_d};
  assign nbits     = {nb, 3'b000};
  assign nb_a      = ADDR_W'(nb);
  assign wlast     = ({1'b0, wcnt_q} == nb - 3'd1);
  assign olast     = ({1'b0, obit_q} == nbits - 6'd1);
  assign rd_act    = (rn_q != 2'b11);
  assign tmo       = (tmr_q == 8'(TIMEOUT - 1));

  always_comb begin
    unique case (width_q)
      2'b00: begin nb = 3'd1; mask = 32'h0000_00ff; lsh = 5'd24; end
      2'b01: begin nb = 3'd2; mask = 32'h0000_ffff; lsh = 5'd16; end
      default: begin nb = 3'd4; mask = 32'hffff_ffff; lsh = 5'd0; end
    endcase
  end

  always_comb begin
    rdat = '0;
    rdy  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_q == CH_W'(c)) begin
        rdat = data_out[32*c +: 32];
        rdy  = data_ready[c];
      end
    end
  end

  // Read words are stored left-aligned so MISO always shifts out bit 31.
  assign cap_d = rdy ? ((rdat & mask) << lsh) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0; busy_q  <= 1'b0;
      miso_q  <= 1'b0; rderr_q <= 1'b0;
      bit_q   <= '0;   sh_q    <= '0;
      wr_q    <= 1'b0; burst_q <= 1'b0;
      width_q <= '0;   wcnt_q  <= '0;
      wn_q    <= 2'b11; rn_q   <= 2'b11;
      chan_q  <= '0;   addr_q  <= '0;
      din_q   <= '0;   tx_q    <= '0;
      pf_q    <= '0;   wacc_q  <= '0;
      wdone_q <= 1'b0; adv_q   <= 1'b0;
      first_q <= 1'b0; iss_q   <= 1'b0;
      txv_q   <= 1'b0; pfv_q   <= 1'b0;
      tmr_q   <= '0;   obit_q  <= '0;
    end else begin
      sclk_q <= spi_clk;
      busy_q <= ~spi_cs_n;
      wn_q   <= 2'b11;
      adv_q  <= 1'b0;
      if (adv_q) addr_q <= addr_q + nb_a;
      if (spi_cs_n) begin
        state_q <= IDLE;
        rn_q    <= 2'b11;
        first_q <= 1'b0; iss_q <= 1'b0;
        txv_q   <= 1'b0; pfv_q <= 1'b0;
      end else begin
        if (rise) begin
          sh_q  <= byte_d[6:0];
          bit_q <= bit_q + 3'd1;
        end
        if (state_q == RWAIT || state_q == RDATA) begin
          if (rd_act) begin
            if (rdy || tmo) begin
              rn_q <= 2'b11;
              if (!rdy) rderr_q <= 1'b1;
              if (first_q) begin
                tx_q    <= cap_d;
                txv_q   <= 1'b1;
                first_q <= 1'b0;
                iss_q   <= burst_q;
              end else begin
                pf_q  <= cap_d;
                pfv_q <= 1'b1;
              end
            end else begin
              tmr_q <= tmr_q + 8'd1;
            end
          end else if (iss_q) begin
            iss_q  <= 1'b0;
            rn_q   <= width_q;
            tmr_q  <= '0;
            addr_q <= addr_q + nb_a;
          end
        end
        unique case (state_q)
          IDLE: begin
            state_q <= CMD;
            bit_q   <= '0;
            rderr_q <= 1'b0;
          end
          CMD: if (byte_done) begin
            wr_q    <= byte_d[7];
            width_q <= (byte_d[6:5] == 2'b11) ? 2'b10 : byte_d[6:5];
            burst_q <= byte_d[4];
            if (32'(byte_d[CH_W-1:0]) >= CHANNELS) chan_q <= '0;
            else chan_q <= byte_d[CH_W-1:0];
            state_q <= ADDR;
          end
          ADDR: if (byte_done) begin
            addr_q  <= byte_d[ADDR_W-1:0];
            wcnt_q  <= '0;
            wacc_q  <= '0;
            wdone_q <= 1'b0;
            if (wr_q) begin
              state_q <= WDATA;
            end else begin
              state_q <= RWAIT;
              rn_q    <= width_q;
              tmr_q   <= '0;
              first_q <= 1'b1;
            end
          end
          WDATA: if (byte_done && !wdone_q) begin
            if (wlast) begin
              din_q  <= wword_d & mask;
              wn_q   <= width_q;
              wcnt_q <= '0;
              wacc_q <= '0;
              if (burst_q) adv_q <= 1'b1;
              else wdone_q <= 1'b1;
            end else begin
              wacc_q <= wword_d[23:0];
              wcnt_q <= wcnt_q + 2'd1;
            end
          end
          RWAIT: if (byte_done) begin
            state_q <= RDATA;
            obit_q  <= '0;
          end
          RDATA: if (fall) begin
            obit_q <= olast ? '0 : obit_q + 5'd1;
            if (obit_q != '0) begin
              miso_q <= tx_q[31];
              tx_q   <= {tx_q[30:0], 1'b0};
            end else if (txv_q) begin
              miso_q <= tx_q[31];
              tx_q   <= {tx_q[30:0], 1'b0};
              txv_q  <= 1'b0;
            end else if (pfv_q) begin
              miso_q <= pf_q[31];
              tx_q   <= {pf_q[30:0], 1'b0};
              pfv_q  <= 1'b0;
              iss_q  <= burst_q;
            end else begin
              miso_q <= 1'b0;
              tx_q   <= '0;
              if (first_q || burst_q) rderr_q <= 1'b1;
            end
            if (obit_q == '0) first_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso     = miso_q;
  assign chan_sel     = chan_q;
  assign address      = addr_q;
  assign data_in      = din_q;
  assign data_write_n = wn_q;
  assign data_read_n  = rn_q;
  assign rd_err       = rderr_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_tqv_spi_bridge.sv
// Directed bench for tqv_spi_bridge: SPI host, peripheral model,
// write/read scoreboards checked with immediate assertions.
module tb_tqv_spi_bridge;
  localparam int ADDR_W   = 6;
  localparam int CHANNELS = 2;
  localparam int TIMEOUT  = 64;
  localparam int CH_W     = 1;
  localparam int H        = 8;
  localparam logic [63:0] RST_V =
    64'({1'b0, CH_W'(0), ADDR_W'(0), 32'd0, 2'b11, 2'b11, 2'b00});

  logic clk = 1'b0, rst = 1'b1;
  logic spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, rd_err, busy;
  logic [CH_W-1:0] chan_sel;
  logic [ADDR_W-1:0] address;
  logic [31:0] data_in;
  logic [1:0] data_write_n, data_read_n;
  logic [32*CHANNELS-1:0] data_out = '0;
  logic [CHANNELS-1:0] data_ready = '0;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  tqv_spi_bridge #(
    .ADDR_W(ADDR_W), .CHANNELS(CHANNELS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .chan_sel(chan_sel), .address(address),
    .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .rd_err(rd_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pdata(int c, logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'(a);
    return {b, 8'hC0 | 8'(c), b ^ 8'h5A, b + 8'd17};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({spi_miso, chan_sel, address, data_in,
                data_write_n, data_read_n, rd_err, busy});
  endfunction

  // Peripheral model: answers the selected channel after ready_dly cycles.
  int ready_dly = 4, rd_cnt = 0, last_len = 0;
  bit use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;
  logic [7:0] rd_log[$];
  always @(negedge clk) begin
    if (!rst && data_read_n != 2'b11) begin
      if (rd_cnt == 0) rd_log.push_back({data_read_n, address});
      rd_cnt++;
    end else if (rd_cnt != 0) begin
      last_len = rd_cnt;
      rd_cnt = 0;
    end
    for (int c = 0; c < CHANNELS; c++)
      data_out[32*c +: 32] = use_fixed ? fixed_val : pdata(c, address);
    data_ready = (rd_cnt >= ready_dly) ? (CHANNELS'(1) << chan_sel) : '0;
  end

  // Write scoreboard: every strobe pops one expected transaction.
  logic [40:0] wq[$];
  logic [1:0] prev_wn = 2'b11;
  int wr_seen = 0;
  always @(negedge clk) begin
    if (!rst && data_write_n != 2'b11) begin
      wr_seen++;
      check("wr_pulse", 64'(prev_wn), 64'd3);
      check("wr_vs_rd", 64'(data_read_n), 64'd3);
      if (wq.size() == 0)
        check("wr_unexpected", 64'(wr_seen), 64'd0);
      else
        check("wr_txn", 64'({chan_sel, address, data_in, data_write_n}),
              64'(wq.pop_front()));
    end
    prev_wn = data_write_n;
  end

  logic [7:0] txq[$], rxq[$];
  logic [31:0] rdq[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n,
                          output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = v[i];
      tick(H);
      r = {r[6:0], spi_miso};
      spi_clk = 1'b1;
      tick(H);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame();
    logic [7:0] r;
    rxq.delete();
    spi_cs_n = 1'b0;
    tick(4);
    check("busy_in_frame", 64'(busy), 64'd1);
    foreach (txq[i]) begin
      spi_bits(txq[i], 8, r);
      rxq.push_back(r);
    end
    tick(H);
    spi_cs_n = 1'b1;
    tick(8);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] rxword(int s, int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = {w[23:0], rxq[s+i]};
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int n, wr_before;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset", outs(), RST_V);

    wq.push_back({1'b1, 6'h05, 32'h12345678, 2'b10});
    txq = '{8'hC1, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
    frame();
    check("w_word_done", 64'(wq.size()), 64'd0);

    wq.push_back({1'b1, 6'h2A, 32'hDEADBEEF, 2'b10});
    txq = '{8'hE1, 8'h2A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    frame();
    check("w_w11_done", 64'(wq.size()), 64'd0);

    wq.push_back({1'b0, 6'h3F, 32'h000000AA, 2'b00});
    wq.push_back({1'b0, 6'h00, 32'h000000BB, 2'b00});
    txq = '{8'h90, 8'h3F, 8'hAA, 8'hBB};
    frame();
    check("w_burst_done", 64'(wq.size()), 64'd0);

    use_fixed = 1'b1;
    fixed_val = 32'hFFFFBEEF;
    ready_dly = 4;
    rd_log.delete();
    rdq.push_back(32'h0000BEEF);
    txq = '{8'h20, 8'h02, 8'h00, 8'h00, 8'h00};
    frame();
    check("rh_data", 64'(rxword(3, 2)), 64'(rdq.pop_front()));
    check("rh_len", 64'(last_len), 64'd4);
    check("rh_nreads", 64'(rd_log.size()), 64'd1);
    if (rd_log.size() > 0)
      check("rh_req", 64'(rd_log.pop_front()), 64'({2'b01, 6'h02}));
    check("rh_err", 64'(rd_err), 64'd0);

    use_fixed = 1'b0;
    rd_log.delete();
    for (int k = 0; k < 3; k++) rdq.push_back(pdata(0, 6'(4 + 4*k)));
    txq = '{8'h50, 8'h04, 8'h00};
    repeat (12) txq.push_back(8'h00);
    frame();
    for (int k = 0; k < 3; k++)
      check("rb_data", 64'(rxword(3 + 4*k, 4)), 64'(rdq.pop_front()));
    check("rb_nreads_min", 64'(rd_log.size() >= 4), 64'd1);
    for (int k = 0; k < 4 && rd_log.size() > 0; k++)
      check("rb_req", 64'(rd_log.pop_front()), 64'({2'b10, 6'(4 + 4*k)}));
    check("rb_err", 64'(rd_err), 64'd0);

    ready_dly = 1000;
    rd_log.delete();
    rdq.push_back(32'h0);
    txq = '{8'h40, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame();
    check("to_data", 64'(rxword(3, 4)), 64'(rdq.pop_front()));
    check("to_len", 64'(last_len), 64'(TIMEOUT));
    check("to_err_held", 64'(rd_err), 64'd1);

    wr_before = wr_seen;
    spi_cs_n = 1'b0;
    tick(4);
    check("err_cleared", 64'(rd_err), 64'd0);
    spi_bits(8'hC0, 8, r);
    spi_bits(8'h10, 8, r);
    spi_bits(8'hFF, 8, r);
    spi_bits(8'hA5, 4, r);
    tick(H);
    spi_cs_n = 1'b1;
    tick(8);
    check("abort_nostrobe", 64'(wr_seen), 64'(wr_before));
    check("abort_idle", 64'({busy, data_write_n}), 64'({1'b0, 2'b11}));

    wq.push_back({1'b1, 6'h3A, 32'h00005AC3, 2'b01});
    txq = '{8'hA1, 8'h3A, 8'h5A, 8'hC3};
    frame();
    check("w_after_abort", 64'(wq.size()), 64'd0);

    spi_cs_n = 1'b0;
    tick(4);
    spi_bits(8'h40, 8, r);
    spi_bits(8'h07, 8, r);
    n = 0;
    while (data_read_n == 2'b11 && n < 200) begin
      tick(1);
      n++;
    end
    check("rst_rd_active", 64'(data_read_n), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async", outs(), RST_V);
    spi_cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("rst_after", outs(), RST_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
